// File: rtl/dcmac_0_axis_pkt_cnt_ext.sv
// Upper-half extension for the DCMAC AXIS per-channel packet/byte statistics counters.
// Counts low-block carries, snapshots on delayed clear edges, and serves a 2-stage read port.
module dcmac_0_axis_pkt_cnt_ext #(
  parameter int unsigned NCH     = 6,
  parameter int unsigned HI_W    = 32,
  parameter int unsigned CLR_DLY = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           i_clear_counters,
  input  logic [2:0]               i_carry_id_m1,
  input  logic                     i_byte_cnt_carry,
  input  logic                     i_pkt_cnt_carry,
  input  logic [NCH-1:0][31:0]     i_lo_byte_cnt,
  input  logic [NCH-1:0][31:0]     i_lo_pkt_cnt,
  input  logic                     i_rd_req,
  input  logic [2:0]               i_rd_id,
  output logic                     o_rd_vld,
  output logic                     o_rd_err,
  output logic [32+HI_W-1:0]       o_rd_byte_cnt,
  output logic [32+HI_W-1:0]       o_rd_pkt_cnt,
  output logic [NCH-1:0]           o_ovf
);

  logic [NCH-1:0]              clr_prev_q;
  logic [CLR_DLY-1:0][NCH-1:0] clr_dly_q;
  logic [NCH-1:0]              clr_edge;
  logic [NCH-1:0]              clr_eff;
  logic [NCH-1:0]              byte_inc;
  logic [NCH-1:0]              pkt_inc;

  logic [NCH-1:0][HI_W-1:0] byte_run_q, byte_run_d;
  logic [NCH-1:0][HI_W-1:0] pkt_run_q, pkt_run_d;
  logic [NCH-1:0][HI_W-1:0] byte_snap_q, byte_snap_d;
  logic [NCH-1:0][HI_W-1:0] pkt_snap_q, pkt_snap_d;
  logic [NCH-1:0]           ovf_q, ovf_d;

  logic                rd_vld1_q;
  logic [2:0]          rd_id1_q;
  logic                rd_err_d;
  logic [32+HI_W-1:0]  rd_byte_d;
  logic [32+HI_W-1:0]  rd_pkt_d;
  logic                rd_vld_q;
  logic                rd_err_q;
  logic [32+HI_W-1:0]  rd_byte_q;
  logic [32+HI_W-1:0]  rd_pkt_q;

  always_comb begin
    clr_edge = i_clear_counters & ~clr_prev_q;
    clr_eff  = clr_dly_q[CLR_DLY-1];
    // Ids at or above NCH never match a channel, so they are dropped here.
    for (int ch = 0; ch < int'(NCH); ch++) begin
      byte_inc[ch] = i_byte_cnt_carry && (i_carry_id_m1 == 3'(ch));
      pkt_inc[ch]  = i_pkt_cnt_carry && (i_carry_id_m1 == 3'(ch));
    end
  end

  always_comb begin
    byte_run_d  = byte_run_q;
    pkt_run_d   = pkt_run_q;
    byte_snap_d = byte_snap_q;
    pkt_snap_d  = pkt_snap_q;
    ovf_d       = ovf_q;
    for (int ch = 0; ch < int'(NCH); ch++) begin
      if (clr_eff[ch]) begin
        // A coincident carry opens the new interval and never raises overflow.
        byte_snap_d[ch] = byte_run_q[ch];
        pkt_snap_d[ch]  = pkt_run_q[ch];
        byte_run_d[ch]  = HI_W'(byte_inc[ch]);
        pkt_run_d[ch]   = HI_W'(pkt_inc[ch]);
        ovf_d[ch]       = 1'b0;
      end else begin
        if (byte_inc[ch]) begin
          byte_run_d[ch] = byte_run_q[ch] + HI_W'(1);
          if (&byte_run_q[ch]) ovf_d[ch] = 1'b1;
        end
        if (pkt_inc[ch]) begin
          pkt_run_d[ch] = pkt_run_q[ch] + HI_W'(1);
          if (&pkt_run_q[ch]) ovf_d[ch] = 1'b1;
        end
      end
    end
  end

  // Stage 2 reads the post-update snapshot so a same-cycle clear is visible.
  always_comb begin
    rd_err_d  = 1'b1;
    rd_byte_d = '0;
    rd_pkt_d  = '0;
    for (int ch = 0; ch < int'(NCH); ch++) begin
      if (rd_id1_q == 3'(ch)) begin
        rd_err_d  = 1'b0;
        rd_byte_d = {byte_snap_d[ch], i_lo_byte_cnt[ch]};
        rd_pkt_d  = {pkt_snap_d[ch], i_lo_pkt_cnt[ch]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_prev_q  <= '0;
      clr_dly_q   <= '0;
      byte_run_q  <= '0;
      pkt_run_q   <= '0;
      byte_snap_q <= '0;
      pkt_snap_q  <= '0;
      ovf_q       <= '0;
      rd_vld1_q   <= 1'b0;
      rd_id1_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_byte_q   <= '0;
      rd_pkt_q    <= '0;
    end else begin
      clr_prev_q   <= i_clear_counters;
      clr_dly_q[0] <= clr_edge;
      for (int i = 1; i < int'(CLR_DLY); i++) begin
        clr_dly_q[i] <= clr_dly_q[i-1];
      end
      byte_run_q  <= byte_run_d;
      pkt_run_q   <= pkt_run_d;
      byte_snap_q <= byte_snap_d;
      pkt_snap_q  <= pkt_snap_d;
      ovf_q       <= ovf_d;
      rd_vld1_q   <= i_rd_req;
      rd_id1_q    <= i_rd_id;
      rd_vld_q    <= rd_vld1_q;
      rd_err_q    <= rd_vld1_q & rd_err_d;
      if (rd_vld1_q) begin
        rd_byte_q <= rd_byte_d;
        rd_pkt_q  <= rd_pkt_d;
      end
    end
  end

  assign o_rd_vld      = rd_vld_q;
  assign o_rd_err      = rd_err_q;
  assign o_rd_byte_cnt = rd_byte_q;
  assign o_rd_pkt_cnt  = rd_pkt_q;
  assign o_ovf         = ovf_q;

endmodule

// File: tb/tb_dcmac_0_axis_pkt_cnt_ext.sv
// Bench for dcmac_0_axis_pkt_cnt_ext: directed scenarios plus randomized traffic
// checked against a cycle-counting reference model of counters and clears.
module tb_dcmac_0_axis_pkt_cnt_ext;

  localparam int NCH     = 6;
  localparam int HI_W    = 4;
  localparam int CLR_DLY = 4;
  localparam int MOD     = 1 << HI_W;
  localparam int DW      = 32 + HI_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       clr;
  logic [2:0]           cid;
  logic                 bcar;
  logic                 pcar;
  logic [NCH-1:0][31:0] lo_b;
  logic [NCH-1:0][31:0] lo_p;
  logic                 rd_req;
  logic [2:0]           rd_id;
  logic                 rd_vld;
  logic                 rd_err;
  logic [DW-1:0]        rd_byte;
  logic [DW-1:0]        rd_pkt;
  logic [NCH-1:0]       ovf;

  int n_run  = 0;
  int n_fail = 0;

  dcmac_0_axis_pkt_cnt_ext #(
    .NCH    (NCH),
    .HI_W   (HI_W),
    .CLR_DLY(CLR_DLY)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_clear_counters(clr),
    .i_carry_id_m1   (cid),
    .i_byte_cnt_carry(bcar),
    .i_pkt_cnt_carry (pcar),
    .i_lo_byte_cnt   (lo_b),
    .i_lo_pkt_cnt    (lo_p),
    .i_rd_req        (rd_req),
    .i_rd_id         (rd_id),
    .o_rd_vld        (rd_vld),
    .o_rd_err        (rd_err),
    .o_rd_byte_cnt   (rd_byte),
    .o_rd_pkt_cnt    (rd_pkt),
    .o_ovf           (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: counters as plain integers, clears scheduled by cycle number.
  int            cyc = 0;
  int            m_run_b[NCH];
  int            m_run_p[NCH];
  int            m_snap_b[NCH];
  int            m_snap_p[NCH];
  int            due_q[NCH][$];
  logic [NCH-1:0] m_prev;
  logic [NCH-1:0] m_ovf;
  bit            m_pend;
  int            m_pid;
  logic          m_vld;
  logic          m_err;
  logic [DW-1:0] m_byte;
  logic [DW-1:0] m_pkt;

  always @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_run_b[ch] = 0; m_run_p[ch] = 0; m_snap_b[ch] = 0; m_snap_p[ch] = 0;
        due_q[ch].delete();
      end
      m_prev = '0; m_ovf = '0; m_pend = 0; m_pid = 0;
      m_vld = 0; m_err = 0; m_byte = '0; m_pkt = '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        bit eff, bi, pi;
        eff = (due_q[ch].size() > 0) && (due_q[ch][0] == cyc);
        if (eff) void'(due_q[ch].pop_front());
        bi = bcar && (int'(cid) == ch);
        pi = pcar && (int'(cid) == ch);
        if (eff) begin
          m_snap_b[ch] = m_run_b[ch];
          m_snap_p[ch] = m_run_p[ch];
          m_run_b[ch]  = bi ? 1 : 0;
          m_run_p[ch]  = pi ? 1 : 0;
          m_ovf[ch]    = 1'b0;
        end else begin
          if (bi) begin
            if (m_run_b[ch] + 1 == MOD) m_ovf[ch] = 1'b1;
            m_run_b[ch] = (m_run_b[ch] + 1) % MOD;
          end
          if (pi) begin
            if (m_run_p[ch] + 1 == MOD) m_ovf[ch] = 1'b1;
            m_run_p[ch] = (m_run_p[ch] + 1) % MOD;
          end
        end
        if (clr[ch] && !m_prev[ch]) due_q[ch].push_back(cyc + CLR_DLY);
        m_prev[ch] = clr[ch];
      end
      m_vld = m_pend;
      if (m_pend) begin
        if (m_pid >= NCH) begin
          m_err = 1; m_byte = '0; m_pkt = '0;
        end else begin
          m_err  = 0;
          m_byte = {HI_W'(m_snap_b[m_pid]), lo_b[m_pid]};
          m_pkt  = {HI_W'(m_snap_p[m_pid]), lo_p[m_pid]};
        end
      end else begin
        m_err = 0;
      end
      m_pend = rd_req;
      m_pid  = int'(rd_id);
    end
    cyc++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic carry(input bit b, input bit p, input int id);
    bcar = b; pcar = p; cid = 3'(id);
    tick();
    bcar = 0; pcar = 0;
  endtask

  // Leaves the bench on the negedge where the response is visible.
  task automatic do_read(input int id);
    rd_req = 1; rd_id = 3'(id);
    tick();
    rd_req = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    rst = 0;
    n_run++;
    if ({rd_vld, rd_err, ovf, rd_byte, rd_pkt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got vld=%b err=%b ovf=%b byte=%h pkt=%h expected all 0",
               rd_vld, rd_err, ovf, rd_byte, rd_pkt);
    end
    for (int id = 0; id < NCH; id++) begin
      rd_req = 1; rd_id = 3'(id);
      tick();
      rd_req = 0;
      n_run++;
      if (rd_vld !== 1'b0) begin
        n_fail++; $display("FAIL reset_rd_early ch%0d: got vld=%b expected 0", id, rd_vld);
      end
      tick();
      n_run++;
      if (rd_vld !== 1'b1 || rd_err !== 1'b0 || rd_byte !== '0 || rd_pkt !== '0) begin
        n_fail++;
        $display("FAIL reset_rd ch%0d: got vld=%b err=%b byte=%h pkt=%h expected 1 0 0 0",
                 id, rd_vld, rd_err, rd_byte, rd_pkt);
      end
    end
  endtask

  task automatic test_carry_clear();
    lo_b[2] = 32'h10; lo_p[2] = 32'h20;
    repeat (3) carry(1, 0, 2);
    carry(0, 1, 2);
    clr[2] = 1;
    repeat (CLR_DLY + 1) tick();
    do_read(2);
    n_run++;
    if (rd_byte !== 36'h3_0000_0010 || rd_pkt !== 36'h1_0000_0020) begin
      n_fail++;
      $display("FAIL carry_clear: got byte=%h pkt=%h expected 300000010 100000020", rd_byte, rd_pkt);
    end
    clr[2] = 0; tick(); clr[2] = 1;
    repeat (CLR_DLY + 1) tick();
    do_read(2);
    n_run++;
    if (rd_byte !== 36'h0_0000_0010 || rd_pkt !== 36'h0_0000_0020) begin
      n_fail++;
      $display("FAIL carry_clear_rerun: got byte=%h pkt=%h expected 000000010 000000020",
               rd_byte, rd_pkt);
    end
    clr[2] = 0;
  endtask

  task automatic test_wrap();
    repeat (MOD - 1) carry(1, 0, 4);
    n_run++;
    if (ovf !== '0) begin
      n_fail++; $display("FAIL wrap_pre: got ovf=%b expected 000000", ovf);
    end
    carry(1, 0, 4);
    n_run++;
    if (ovf !== 6'b010000) begin
      n_fail++; $display("FAIL wrap_set: got ovf=%b expected 010000", ovf);
    end
    clr[4] = 1;
    repeat (CLR_DLY) tick();
    n_run++;
    if (ovf !== 6'b010000) begin
      n_fail++; $display("FAIL wrap_sticky: got ovf=%b expected 010000", ovf);
    end
    tick();
    n_run++;
    if (ovf !== '0) begin
      n_fail++; $display("FAIL wrap_clear: got ovf=%b expected 000000", ovf);
    end
    do_read(4);
    n_run++;
    if (rd_byte !== {4'h0, lo_b[4]} || rd_err !== 1'b0) begin
      n_fail++; $display("FAIL wrap_snap: got byte=%h err=%b expected %h 0", rd_byte, rd_err,
                         {4'h0, lo_b[4]});
    end
    clr[4] = 0;
  endtask

  task automatic test_coincident();
    repeat (5) carry(1, 1, 1);
    clr[1] = 1;
    repeat (CLR_DLY) tick();
    carry(1, 1, 1);
    do_read(1);
    n_run++;
    if (rd_byte[DW-1:32] !== 4'd5 || rd_pkt[DW-1:32] !== 4'd5) begin
      n_fail++; $display("FAIL coincident_snap: got byte_hi=%0d pkt_hi=%0d expected 5 5",
                         rd_byte[DW-1:32], rd_pkt[DW-1:32]);
    end
    clr[1] = 0; tick(); clr[1] = 1;
    repeat (CLR_DLY + 1) tick();
    do_read(1);
    n_run++;
    if (rd_byte[DW-1:32] !== 4'd1 || rd_pkt[DW-1:32] !== 4'd1) begin
      n_fail++; $display("FAIL coincident_next: got byte_hi=%0d pkt_hi=%0d expected 1 1",
                         rd_byte[DW-1:32], rd_pkt[DW-1:32]);
    end
    clr[1] = 0;
  endtask

  task automatic test_held_clear();
    int k = 0;
    repeat (2) carry(1, 0, 0);
    clr[0] = 1;
    cid = 0;
    for (int i = 0; i < 20; i++) begin
      bcar = (i > CLR_DLY) && (i % 2 == 0);
      if (bcar) k++;
      tick();
    end
    bcar = 0;
    do_read(0);
    n_run++;
    if (rd_byte[DW-1:32] !== 4'd2) begin
      n_fail++; $display("FAIL held_clear_once: got byte_hi=%0d expected 2", rd_byte[DW-1:32]);
    end
    clr[0] = 0; tick(); clr[0] = 1;
    repeat (CLR_DLY + 1) tick();
    do_read(0);
    n_run++;
    if (rd_byte[DW-1:32] !== 4'(k)) begin
      n_fail++; $display("FAIL held_clear_accum: got byte_hi=%0d expected %0d",
                         rd_byte[DW-1:32], k);
    end
    clr[0] = 0;
  endtask

  task automatic test_back_to_back();
    rd_req = 1; rd_id = 3'd0;
    tick();
    rd_id = 3'd7;
    tick();
    n_run++;
    if (rd_vld !== 1'b1 || rd_err !== 1'b0 || rd_byte !== m_byte || rd_pkt !== m_pkt) begin
      n_fail++; $display("FAIL b2b_id0: got vld=%b err=%b byte=%h pkt=%h expected 1 0 %h %h",
                         rd_vld, rd_err, rd_byte, rd_pkt, m_byte, m_pkt);
    end
    rd_id = 3'd3;
    tick();
    n_run++;
    if (rd_vld !== 1'b1 || rd_err !== 1'b1 || rd_byte !== '0 || rd_pkt !== '0) begin
      n_fail++; $display("FAIL b2b_id7: got vld=%b err=%b byte=%h pkt=%h expected 1 1 0 0",
                         rd_vld, rd_err, rd_byte, rd_pkt);
    end
    rd_req = 0; rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      n_run++;
      if (rd_vld !== 1'b0) begin
        n_fail++; $display("FAIL b2b_rst_drop %0d: got vld=%b expected 0", i, rd_vld);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      n_run++;
      if (rd_vld !== m_vld || rd_err !== m_err || rd_byte !== m_byte || rd_pkt !== m_pkt ||
          ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL random cyc%0d: got vld=%b err=%b byte=%h pkt=%h ovf=%b expected %b %b %h %h %b",
                 i, rd_vld, rd_err, rd_byte, rd_pkt, ovf, m_vld, m_err, m_byte, m_pkt, m_ovf);
      end
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 39) == 0) clr[ch] = ~clr[ch];
        if ($urandom_range(0, 3) == 0) lo_b[ch] = $urandom;
        if ($urandom_range(0, 3) == 0) lo_p[ch] = $urandom;
      end
      cid    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      bcar   = ($urandom_range(0, 3) != 0);
      pcar   = ($urandom_range(0, 1) != 0);
      rd_req = ($urandom_range(0, 1) != 0);
      rd_id  = 3'($urandom_range(0, 7));
      tick();
    end
    bcar = 0; pcar = 0; rd_req = 0;
  endtask

  initial begin
    rst = 1; clr = '0; cid = '0; bcar = 0; pcar = 0;
    lo_b = '0; lo_p = '0; rd_req = 0; rd_id = '0;
    test_reset();
    test_carry_clear();
    test_wrap();
    test_coincident();
    test_held_clear();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
